// File: rtl/mul_issue_pkg.sv
// mul_issue_pkg
// Shared definitions for the multiplier issue controller: the request opcode
// encoding, operand/product widths and the opcode decode helpers used to
// steer the multiplier's signedness and the result-half selection.
package mul_issue_pkg;

  localparam int OPND_W = 32;  // operand and result width
  localparam int OP_W   = 2;   // request opcode width
  localparam int PROD_W = 64;  // full product width from the multiplier

  typedef enum logic [OP_W-1:0] {
    OP_MUL   = 2'b00,  // low 32 bits of the product
    OP_MULH  = 2'b01,  // signed x signed, high 32 bits
    OP_MULHU = 2'b10,  // unsigned x unsigned, high 32 bits
    OP_RSVD  = 2'b11   // reserved, executes as OP_MUL
  } mulOp_e;

  // True when the op returns the upper half of the product.
  function automatic logic is_hi(input mulOp_e op);
    return (op == OP_MULH) || (op == OP_MULHU);
  endfunction

  // True when the multiplier must treat both operands as signed.
  // The low half of the product does not depend on signedness, so only
  // MULH needs it.
  function automatic logic is_signed(input mulOp_e op);
    return op == OP_MULH;
  endfunction

endpackage

// File: rtl/mul_issue_stage.sv
// mul_issue_stage
// Generic valid/payload pipeline register with load enable and flush.
//
// Ports:
//   mul_clk   clock, rising edge
//   resetn    asynchronous active-low reset; clears valid and payload
//   en        stage may load this cycle (downstream has room)
//   flush     synchronous kill; clears valid, highest priority
//   inValid   upstream holds a valid item
//   inData    upstream payload
//   valid     stage holds a valid item
//   validNxt  value valid takes at the next edge (for registered counts)
//   data      stage payload
module mul_issue_stage #(
  parameter int W = 8
) (
  input  logic         mul_clk,
  input  logic         resetn,
  input  logic         en,
  input  logic         flush,
  input  logic         inValid,
  input  logic [W-1:0] inData,
  output logic         valid,
  output logic         validNxt,
  output logic [W-1:0] data
);

  always_comb begin
    validNxt = valid;
    if (flush)   validNxt = 1'b0;
    else if (en) validNxt = inValid;
  end

  // Payload only moves when a valid item is loaded; an empty stage keeps
  // whatever it last held, which is never observed while valid is low.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= validNxt;
      if (en && inValid && !flush) data <= inData;
    end
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
// Issue/sequencing control for the two-stage Booth/Wallace multiplier in the
// execute stage. Requests (MUL/MULH/MULHU) are accepted over valid/ready,
// registered in S1 to drive the multiplier operands, shadowed through the
// multiplier's internal register (S2), and the selected product half is
// registered in OUT with backpressure. One request per cycle when unstalled;
// three cycles from accept to out_valid.
//
// Ports:
//   mul_clk, resetn        clock / asynchronous active-low reset
//   flush                  kills every in-flight and pending-output op
//   in_valid/in_ready      request handshake
//   in_op, in_x, in_y      opcode and operands
//   in_tag                 opaque request tag
//   mul_x, mul_y           operands to the multiplier
//   mul_signed             multiplier signedness
//   mul_capture            multiplier stage-register load enable
//   mul_result             multiplier product (from its stage register)
//   out_valid/out_ready    result handshake
//   out_data, out_tag      selected result half and its tag
//   busy                   any stage valid
//   inflight               number of valid stages (0..3)
module mul_issue_ctrl
  import mul_issue_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                mul_clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     in_op,
  input  logic [OPND_W-1:0]   in_x,
  input  logic [OPND_W-1:0]   in_y,
  input  logic [TAG_W-1:0]    in_tag,
  output logic [OPND_W-1:0]   mul_x,
  output logic [OPND_W-1:0]   mul_y,
  output logic                mul_signed,
  output logic                mul_capture,
  input  logic [PROD_W-1:0]   mul_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPND_W-1:0]   out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy,
  output logic [1:0]          inflight
);

  localparam int S1_W  = 2 * OPND_W + OP_W + TAG_W;
  localparam int S2_W  = 1 + TAG_W;
  localparam int OUT_W = OPND_W + TAG_W;

  logic outEn, s2En, s1En, accept;
  logic s1Valid, s2Valid, outValid;
  logic s1Nxt, s2Nxt, outNxt;

  logic [S1_W-1:0]  s1In, s1Q;
  logic [S2_W-1:0]  s2In, s2Q;
  logic [OUT_W-1:0] outIn, outQ;

  logic [OP_W-1:0]  s1OpRaw;
  mulOp_e           s1Op;
  logic [TAG_W-1:0] s1Tag;
  logic             s2Hi;
  logic [TAG_W-1:0] s2Tag;
  logic [1:0]       inflightQ;

  // Ready ripples back from the output: each stage may load when it is
  // empty or the stage after it is moving this cycle.
  always_comb begin
    outEn       = !outValid || out_ready;
    s2En        = !s2Valid || outEn;
    s1En        = !s1Valid || s2En;
    in_ready    = s1En && !flush;
    accept      = in_valid && in_ready;
    // The multiplier's stage register is S2; it loads exactly when the S2
    // shadow does, so its product stays aligned with s2Hi/s2Tag.
    mul_capture = s2En;
  end

  // S1: operands, opcode and tag of the request feeding the multiplier.
  assign s1In = {in_x, in_y, in_op, in_tag};

  mul_issue_stage #(.W(S1_W)) u_s1 (
    .mul_clk  (mul_clk),
    .resetn   (resetn),
    .en       (s1En),
    .flush    (flush),
    .inValid  (accept),
    .inData   (s1In),
    .valid    (s1Valid),
    .validNxt (s1Nxt),
    .data     (s1Q)
  );

  assign {mul_x, mul_y, s1OpRaw, s1Tag} = s1Q;
  assign s1Op       = mulOp_e'(s1OpRaw);
  assign mul_signed = is_signed(s1Op);

  // S2 shadow: bookkeeping that travels alongside the multiplier's product.
  assign s2In = {is_hi(s1Op), s1Tag};

  mul_issue_stage #(.W(S2_W)) u_s2 (
    .mul_clk  (mul_clk),
    .resetn   (resetn),
    .en       (s2En),
    .flush    (flush),
    .inValid  (s1Valid),
    .inData   (s2In),
    .valid    (s2Valid),
    .validNxt (s2Nxt),
    .data     (s2Q)
  );

  assign {s2Hi, s2Tag} = s2Q;

  // OUT: selected product half, registered for the consumer.
  assign outIn = {(s2Hi ? mul_result[PROD_W-1:OPND_W] : mul_result[OPND_W-1:0]), s2Tag};

  mul_issue_stage #(.W(OUT_W)) u_out (
    .mul_clk  (mul_clk),
    .resetn   (resetn),
    .en       (outEn),
    .flush    (flush),
    .inValid  (s2Valid),
    .inData   (outIn),
    .valid    (outValid),
    .validNxt (outNxt),
    .data     (outQ)
  );

  assign {out_data, out_tag} = outQ;
  assign out_valid = outValid;
  assign busy      = s1Valid || s2Valid || outValid;

  // Counted from the next-state valid bits so the registered value always
  // matches the stage valids it describes, with no extra cycle of lag.
  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) inflightQ <= '0;
    else         inflightQ <= {1'b0, s1Nxt} + {1'b0, s2Nxt} + {1'b0, outNxt};
  end

  assign inflight = inflightQ;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

  localparam int TAG_W = 4;

  logic             mul_clk = 1'b0;
  logic             resetn;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_x, in_y;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      mul_x, mul_y;
  logic             mul_signed;
  logic             mul_capture;
  logic [63:0]      mul_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
  logic [1:0]       inflight;

  always #5 mul_clk = ~mul_clk;

  mul_issue_ctrl #(.TAG_W(TAG_W)) dut (
    .mul_clk     (mul_clk),
    .resetn      (resetn),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_tag      (in_tag),
    .mul_x       (mul_x),
    .mul_y       (mul_y),
    .mul_signed  (mul_signed),
    .mul_capture (mul_capture),
    .mul_result  (mul_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .busy        (busy),
    .inflight    (inflight)
  );

  // Multiplier model: one stage register loaded when mul_capture is high.
  logic [63:0] mulReg;
  logic [63:0] xe, ye;
  always_comb begin
    xe = mul_signed ? {{32{mul_x[31]}}, mul_x} : {32'b0, mul_x};
    ye = mul_signed ? {{32{mul_y[31]}}, mul_y} : {32'b0, mul_y};
  end
  always @(posedge mul_clk) if (mul_capture) mulReg <= xe * ye;
  assign mul_result = mulReg;

  int nCmp = 0;
  int nErr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the request itself.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ps;
    logic [63:0] pu;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ps = sx * sy;
    pu = {32'b0, x} * {32'b0, y};
    case (op)
      2'b01:   return ps[63:32];
      2'b10:   return pu[63:32];
      default: return pu[31:0];
    endcase
  endfunction

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } sb_t;
  sb_t sbq[$];

  // Scoreboard: push on accept, pop/compare when the consumer takes a result.
  always @(negedge mul_clk) begin
    if (!resetn) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          nCmp++;
          nErr++;
          $display("FAIL sb_unexpected: got output tag %0h data %0h, expected none at %0t",
                   out_tag, out_data, $time);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          check("sb_data", 64'(out_data), 64'(e.data));
          check("sb_tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready) sbq.push_back('{data: model(in_op, in_x, in_y), tag: in_tag});
    end
  end

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      x;
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
    logic             sgn;
  } vec_t;
  vec_t vecs[10];

  // Single isolated request with fixed-latency checks (out_ready held 1).
  task automatic runVec(input vec_t v);
    in_op = v.op; in_x = v.x; in_y = v.y; in_tag = v.tag; in_valid = 1'b1;
    check("vec_in_ready", 64'(in_ready), 64'(1));
    @(posedge mul_clk); #1;
    in_valid = 1'b0;
    check("vec_signed", 64'(mul_signed), 64'(v.sgn));
    check("vec_mul_x", 64'(mul_x), 64'(v.x));
    check("vec_lat_e0", 64'(out_valid), 64'(0));
    @(posedge mul_clk); #1;
    check("vec_lat_e1", 64'(out_valid), 64'(0));
    @(posedge mul_clk); #1;
    check("vec_valid", 64'(out_valid), 64'(1));
    check("vec_data", 64'(out_data), 64'(v.exp));
    check("vec_tag", 64'(out_tag), 64'(v.tag));
    @(posedge mul_clk); #1;
    check("vec_drained", 64'(out_valid), 64'(0));
  endtask

  task automatic setReq(input int k);
    in_op  = 2'(k % 3);
    in_x   = 32'hF000_0010 + 32'(k * 37);
    in_y   = 32'h0001_0003 + 32'(k * 11);
    in_tag = TAG_W'(k);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 40) begin
      @(posedge mul_clk); #1;
      n++;
    end
    check(name, 64'(n < 40), 64'(1));
  endtask

  initial begin
    int k;
    logic acc;

    vecs[0] = '{op: 2'b00, x: 32'h0000_0003, y: 32'h0000_0005, tag: 4'h1, exp: 32'h0000_000F, sgn: 1'b0};
    vecs[1] = '{op: 2'b01, x: 32'hFFFF_FFFF, y: 32'h0000_0002, tag: 4'h2, exp: 32'hFFFF_FFFF, sgn: 1'b1};
    vecs[2] = '{op: 2'b10, x: 32'hFFFF_FFFF, y: 32'h0000_0002, tag: 4'h3, exp: 32'h0000_0001, sgn: 1'b0};
    vecs[3] = '{op: 2'b11, x: 32'h0000_0003, y: 32'h0000_0005, tag: 4'h4, exp: 32'h0000_000F, sgn: 1'b0};
    vecs[4] = '{op: 2'b10, x: 32'hFFFF_FFFF, y: 32'hFFFF_FFFF, tag: 4'h5, exp: 32'hFFFF_FFFE, sgn: 1'b0};
    vecs[5] = '{op: 2'b01, x: 32'hFFFF_FFFF, y: 32'hFFFF_FFFF, tag: 4'h6, exp: 32'h0000_0000, sgn: 1'b1};
    vecs[6] = '{op: 2'b00, x: 32'h1234_5678, y: 32'h0000_0010, tag: 4'h7, exp: 32'h2345_6780, sgn: 1'b0};
    vecs[7] = '{op: 2'b01, x: 32'h7FFF_FFFF, y: 32'h7FFF_FFFF, tag: 4'h8, exp: 32'h3FFF_FFFF, sgn: 1'b1};
    vecs[8] = '{op: 2'b01, x: 32'hFFFF_FFFE, y: 32'h0000_0003, tag: 4'h9, exp: 32'hFFFF_FFFF, sgn: 1'b1};
    vecs[9] = '{op: 2'b10, x: 32'h8000_0000, y: 32'h0000_0002, tag: 4'hA, exp: 32'h0000_0001, sgn: 1'b0};

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_x = '0; in_y = '0; in_tag = '0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_inflight", 64'(inflight), 64'(0));
    check("rst_mul_x", 64'(mul_x), 64'(0));
    check("rst_mul_capture", 64'(mul_capture), 64'(1));
    #10 resetn = 1'b1;
    @(posedge mul_clk); #1;

    // Table of isolated requests.
    for (int i = 0; i < 10; i++) runVec(vecs[i]);

    // Eight back-to-back MULs: results in eight consecutive cycles.
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8);
      in_op = 2'b00; in_x = 32'(c); in_y = 32'(c + 1); in_tag = TAG_W'(c);
      if (c < 8) check("b2b_in_ready", 64'(in_ready), 64'(1));
      @(posedge mul_clk); #1;
      check("b2b_valid", 64'(out_valid), 64'(c >= 2 && c < 10));
      if (c >= 2 && c < 10) begin
        check("b2b_data", 64'(out_data), 64'((c - 2) * (c - 1)));
        check("b2b_tag", 64'(out_tag), 64'(c - 2));
      end
    end
    in_valid = 1'b0;
    drain("b2b_drain");

    // Backpressure: consumer stalls for five cycles while requests keep coming.
    out_ready = 1'b0;
    k = 0;
    setReq(k);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("stall_in_ready", 64'(in_ready), 64'(c < 3));
      if (c >= 3) begin
        check("stall_capture", 64'(mul_capture), 64'(0));
        check("stall_inflight", 64'(inflight), 64'(3));
      end
      acc = in_ready;
      @(posedge mul_clk); #1;
      if (acc) begin k++; setReq(k); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && k < 8; c++) begin
      acc = in_ready;
      @(posedge mul_clk); #1;
      if (acc) begin k++; setReq(k); end
    end
    in_valid = 1'b0;
    check("stall_issued", 64'(k), 64'(8));
    drain("stall_drain");

    // Flush with all three stages full and a request offered.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      setReq(c + 20);
      check("fill_in_ready", 64'(in_ready), 64'(1));
      @(posedge mul_clk); #1;
    end
    check("fill_inflight", 64'(inflight), 64'(3));
    in_op = 2'b00; in_x = 32'd9; in_y = 32'd9; in_tag = 4'hF;
    flush = 1'b1; out_ready = 1'b1;
    check("flush_in_ready", 64'(in_ready), 64'(0));
    @(posedge mul_clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_inflight", 64'(inflight), 64'(0));
    for (int c = 0; c < 4; c++) begin
      @(posedge mul_clk); #1;
      check("flush_no_ghost", 64'(out_valid), 64'(0));
    end

    // Asynchronous reset in the middle of a stream.
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      setReq(c + 40);
      @(posedge mul_clk); #1;
    end
    #2 resetn = 1'b0; in_valid = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_out_data", 64'(out_data), 64'(0));
    check("arst_out_tag", 64'(out_tag), 64'(0));
    check("arst_mul_x", 64'(mul_x), 64'(0));
    check("arst_mul_y", 64'(mul_y), 64'(0));
    check("arst_mul_signed", 64'(mul_signed), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_inflight", 64'(inflight), 64'(0));
    check("arst_capture", 64'(mul_capture), 64'(1));
    #10 resetn = 1'b1;
    @(posedge mul_clk); #1;
    runVec('{op: 2'b00, x: 32'd7, y: 32'd6, tag: 4'h3, exp: 32'd42, sgn: 1'b0});
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
